// File: rtl/uart_pkg.sv
// Shared UART settings and baud increment math.
// Used by the baud generator and by UART TX/RX.
package uart_pkg;

  localparam int unsigned DEF_CLOCK_FREQ = 192000;
  localparam int unsigned DEF_BAUD_RATE  = 9600;
  localparam int unsigned DEF_OVERSAMPLE = 16;
  localparam int unsigned DEF_ACC_WIDTH  = 16;

  // round(baud * os * 2^w / clk) in 64-bit math
  function automatic longint unsigned calc_incr(
    input longint unsigned clock_freq,
    input longint unsigned baud_rate,
    input longint unsigned oversample,
    input int unsigned     acc_width
  );
    longint unsigned num;
    num = (baud_rate * oversample) << acc_width;
    return (2 * num + clock_freq) / (2 * clock_freq);
  endfunction

endpackage

// File: rtl/uart_phase_acc.sv
// Phase accumulator with shadowed increment.
// Shadow value lands on the bit-ending wrap.
module uart_phase_acc #(
  parameter int unsigned          ACC_WIDTH = 16,
  parameter logic [ACC_WIDTH-1:0] INIT_INCR = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 restart,
  input  logic                 bit_last,
  input  logic                 cfg_load,
  input  logic [ACC_WIDTH-1:0] cfg_incr,
  output logic                 wrap,
  output logic                 cfg_pending
);

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] incr;
  logic [ACC_WIDTH-1:0] shadow;
  logic [ACC_WIDTH:0]   sum;
  logic                 step;
  logic                 apply;
  logic                 direct;

  assign sum    = {1'b0, acc} + {1'b0, incr};
  assign step   = enable & ~restart;
  assign wrap   = step & sum[ACC_WIDTH];
  assign apply  = wrap & bit_last;
  assign direct = cfg_load & (~step | apply);

  // Phase register: advance, realign or hold
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      acc <= '0;
    end else if (enable) begin
      acc <= sum[ACC_WIDTH-1:0];
    end
  end

  // Increment and shadow: direct write, shadow capture or deferred apply
  always_ff @(posedge clk) begin
    if (reset) begin
      incr        <= INIT_INCR;
      shadow      <= '0;
      cfg_pending <= 1'b0;
    end else if (direct) begin
      incr        <= cfg_incr;
      cfg_pending <= 1'b0;
    end else if (cfg_load) begin
      shadow      <= cfg_incr;
      cfg_pending <= 1'b1;
    end else if (cfg_pending && (restart || apply)) begin
      incr        <= shadow;
      cfg_pending <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// Fractional baud generator: oversample and bit ticks.
// Phase accumulator wraps feed a power-of-two os counter.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = DEF_CLOCK_FREQ,
  parameter int unsigned BAUD_RATE  = DEF_BAUD_RATE,
  parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int unsigned ACC_WIDTH  = DEF_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 restart,
  input  logic [ACC_WIDTH-1:0] cfg_incr,
  input  logic                 cfg_load,
  output logic                 cfg_pending,
  output logic                 os_tick,
  output logic                 baud_tick,
  output logic                 baud_out
);

  localparam int unsigned OS_W = $clog2(OVERSAMPLE);
  localparam longint unsigned INCR_L = calc_incr(
    longint'(CLOCK_FREQ), longint'(BAUD_RATE),
    longint'(OVERSAMPLE), ACC_WIDTH);
  localparam logic [ACC_WIDTH-1:0] DEFAULT_INCR =
    INCR_L[ACC_WIDTH-1:0];

  if (longint'(BAUD_RATE) * OVERSAMPLE >= longint'(CLOCK_FREQ))
  begin : g_bad_rate
    $error("BAUD_RATE*OVERSAMPLE must be below CLOCK_FREQ");
  end

  if (OVERSAMPLE < 4 || OVERSAMPLE > 64 ||
      (OVERSAMPLE & (OVERSAMPLE - 1)) != 0)
  begin : g_bad_os
    $error("OVERSAMPLE must be a power of two in 4..64");
  end

  logic [OS_W-1:0] os_cnt;
  logic [OS_W-1:0] os_nxt;
  logic            wrap;
  logic            bit_last;

  assign bit_last = (os_cnt == OS_W'(OVERSAMPLE - 1));
  assign os_nxt   = os_cnt + OS_W'(1);

  uart_phase_acc #(
    .ACC_WIDTH (ACC_WIDTH),
    .INIT_INCR (DEFAULT_INCR)
  ) u_acc (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .restart     (restart),
    .bit_last    (bit_last),
    .cfg_load    (cfg_load),
    .cfg_incr    (cfg_incr),
    .wrap        (wrap),
    .cfg_pending (cfg_pending)
  );

  // Oversample counter, tick pulses and bit-rate square wave
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      os_cnt    <= '0;
      os_tick   <= 1'b0;
      baud_tick <= 1'b0;
      baud_out  <= 1'b0;
    end else if (enable) begin
      os_tick   <= wrap;
      baud_tick <= wrap & bit_last;
      if (wrap) begin
        os_cnt   <= os_nxt;
        baud_out <= os_nxt[OS_W-1];
      end
    end else begin
      os_tick   <= 1'b0;
      baud_tick <= 1'b0;
    end
  end

endmodule
